// File: rtl/gf_pkg.sv
// ----------------------------------------------------------------------------
// gf_pkg
//   Shared constants and types for the Reed-Solomon decoder datapath.
//   SYMB_WIDTH : GF symbol width in bits
//   T_LEN      : maximum number of correctable symbol errors per codeword
//   CNT_W      : width of an error count (0..T_LEN inclusive)
//   TAG_W      : width of an index into a T_LEN-entry vector
// ----------------------------------------------------------------------------
package gf_pkg;

    localparam int SYMB_WIDTH = 8;
    localparam int T_LEN      = 8;
    localparam int CNT_W      = $clog2(T_LEN + 1);
    localparam int TAG_W      = $clog2(T_LEN);

    typedef logic [SYMB_WIDTH-1:0] symb_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } forney_state_t;

endpackage

// File: rtl/rs_forney_sched.sv
// ----------------------------------------------------------------------------
// rs_forney_sched
//   Time-shares one Forney evaluator across the error positions of a codeword.
//   A codeword (position vector + error count) is captured, positions are
//   issued one per cycle with their index as tag, tagged magnitudes are
//   collected in any order, and the completed magnitude vector is presented
//   with a fail flag.
//
// Ports
//   aclk, areset        clock, synchronous active-high reset
//   error_positions     error locations from the Chien search
//   err_num             number of valid entries in error_positions
//   err_vld / err_rdy   codeword input handshake
//   ev_pos, ev_tag      position and its index issued to the evaluator
//   ev_vld / ev_rdy     issue handshake
//   ev_mag, ev_mag_tag  returned magnitude and the index it belongs to
//   ev_mag_vld          magnitude valid (no backpressure)
//   err_values          magnitudes, indexed like error_positions
//   err_fail            codeword uncorrectable
//   out_vld / out_rdy   result handshake
// ----------------------------------------------------------------------------
module rs_forney_sched
    import gf_pkg::*;
(
    input  logic              aclk,
    input  logic              areset,
    input  symb_t [T_LEN-1:0] error_positions,
    input  logic [CNT_W-1:0]  err_num,
    input  logic              err_vld,
    output logic              err_rdy,
    output symb_t             ev_pos,
    output logic [TAG_W-1:0]  ev_tag,
    output logic              ev_vld,
    input  logic              ev_rdy,
    input  symb_t             ev_mag,
    input  logic [TAG_W-1:0]  ev_mag_tag,
    input  logic              ev_mag_vld,
    output symb_t [T_LEN-1:0] err_values,
    output logic              err_fail,
    output logic              out_vld,
    input  logic              out_rdy
);

    forney_state_t     state;
    symb_t [T_LEN-1:0] pos_q;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  ret_cnt;
    logic [T_LEN-1:0]  ret_mask;
    logic [TAG_W-1:0]  issue_tag;
    logic              ret_ok;
    logic              ret_done;

    // While issuing, issue_cnt < err_num <= T_LEN, so its low bits are a
    // valid index; the position is read straight from the captured vector
    // so it stays stable for as long as the evaluator stalls.
    assign issue_tag = issue_cnt[TAG_W-1:0];
    assign ev_tag    = issue_tag;
    assign ev_pos    = pos_q[issue_tag];

    // A return is only accepted once per tag and only for tags in range;
    // anything else leaves err_values untouched and flags the codeword.
    assign ret_ok   = (CNT_W'(ev_mag_tag) < num_q) && !ret_mask[ev_mag_tag];
    assign ret_done = (ret_cnt == num_q);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            err_rdy    <= 1'b1;
            ev_vld     <= 1'b0;
            out_vld    <= 1'b0;
            err_fail   <= 1'b0;
            err_values <= '0;
            ret_mask   <= '0;
            issue_cnt  <= '0;
            ret_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (err_vld) begin
                        pos_q      <= error_positions;
                        num_q      <= err_num;
                        err_values <= '0;
                        ret_mask   <= '0;
                        err_fail   <= 1'b0;
                        issue_cnt  <= '0;
                        ret_cnt    <= '0;
                        err_rdy    <= 1'b0;
                        if (err_num == '0) begin
                            state   <= DONE;
                            out_vld <= 1'b1;
                        end else if (err_num > CNT_W'(T_LEN)) begin
                            // Too many errors to correct: report without issuing.
                            state    <= DONE;
                            out_vld  <= 1'b1;
                            err_fail <= 1'b1;
                        end else begin
                            state  <= ISSUE;
                            ev_vld <= 1'b1;
                        end
                    end
                end

                ISSUE, DRAIN: begin
                    if (ret_done) begin
                        state   <= DONE;
                        out_vld <= 1'b1;
                        ev_vld  <= 1'b0;
                    end else begin
                        if (ev_vld && ev_rdy) begin
                            issue_cnt <= issue_cnt + CNT_W'(1);
                            if (issue_cnt == num_q - CNT_W'(1)) begin
                                state  <= DRAIN;
                                ev_vld <= 1'b0;
                            end
                        end
                        if (ev_mag_vld) begin
                            if (ret_ok) begin
                                err_values[ev_mag_tag] <= ev_mag;
                                ret_mask[ev_mag_tag]   <= 1'b1;
                                ret_cnt                <= ret_cnt + CNT_W'(1);
                                // A zero magnitude at an error position means
                                // the locator and evaluator disagree.
                                if (ev_mag == '0) begin
                                    err_fail <= 1'b1;
                                end
                            end else begin
                                err_fail <= 1'b1;
                            end
                        end
                    end
                end

                DONE: begin
                    if (out_rdy) begin
                        state   <= IDLE;
                        out_vld <= 1'b0;
                        err_rdy <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/rs_forney_sched.md
Name: rs_forney_sched

Overview:
- Sequencer that time-shares one Forney evaluator (error-magnitude datapath) across up to T_LEN error positions of a codeword.
- Sits between the Chien search output and the correction stage of the RS decoder.
- Captures a position vector and an error count, then issues positions one per cycle to the evaluator.
- Collects tagged magnitudes, which may return out of order, and presents the full magnitude vector with a fail flag.

Parameters:
SYMB_WIDTH, 8, GF symbol width (from gf_pkg)
T_LEN, 8, max correctable errors (from gf_pkg)
CNT_W, $clog2(T_LEN+1), width of error count
TAG_W, $clog2(T_LEN), width of evaluator tag

Ports:
aclk  in  1  clock; all logic on posedge
areset  in  1  reset, synchronous, active-high
error_positions  in  SYMB_WIDTH x [T_LEN]  error locations from Chien
err_num  in  CNT_W  number of valid entries in error_positions
err_vld  in  1  input valid
err_rdy  out  1  scheduler can accept a codeword
ev_pos  out  SYMB_WIDTH  position issued to evaluator
ev_tag  out  TAG_W  index of issued position
ev_vld  out  1  issue valid
ev_rdy  in  1  evaluator accepts issue
ev_mag  in  SYMB_WIDTH  returned magnitude
ev_mag_tag  in  TAG_W  index of returned magnitude
ev_mag_vld  in  1  magnitude valid; no backpressure
err_values  out  SYMB_WIDTH x [T_LEN]  magnitudes, indexed as error_positions
err_fail  out  1  codeword uncorrectable
out_vld  out  1  result valid
out_rdy  in  1  downstream accepts result

Behaviour:
- Reset (sync, active-high, wins over all inputs): state IDLE; err_rdy=1; ev_vld=0; out_vld=0; err_fail=0; err_values all 0; issue/return counters 0. Reset mid-operation discards the codeword; magnitudes that arrive later are ignored while in IDLE.
- Input handshake: a transfer happens on err_vld & err_rdy. err_rdy=1 only in IDLE. On transfer, latch positions and err_num, clear err_values and the return mask.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE -> DONE on transfer when err_num==0: err_values=0, err_fail=0.
- IDLE -> DONE on transfer when err_num>T_LEN: err_fail=1, nothing issued.
- IDLE -> ISSUE on any other transfer.
- ISSUE: ev_vld=1, ev_pos=pos[issue_cnt], ev_tag=issue_cnt. Each ev_vld & ev_rdy increments issue_cnt. ev_pos and ev_tag stay stable while ev_rdy=0. After the issue with issue_cnt==err_num-1 -> DRAIN, with ev_vld low in the next cycle.
- Returns (in ISSUE or DRAIN): on ev_mag_vld, write err_values[ev_mag_tag]=ev_mag and set mask bit; increment ret_cnt.
  - Tag >= err_num, or a duplicate tag: result ignored, sticky err_fail set.
  - Zero magnitude: sticky err_fail set.
  - A return arriving in the same cycle as an issue is legal.
- DRAIN (or ISSUE) -> DONE in the cycle after ret_cnt reaches err_num.
- DONE: out_vld=1; err_values and err_fail held stable until out_vld & out_rdy, then -> IDLE with out_vld=0. A new codeword is accepted the cycle after.
- Throughput: one issue per cycle when ev_rdy is held high. Minimum latency from transfer to out_vld is err_num + evaluator latency + 1 cycles.
- err_fail is cleared on each input transfer.
- Counters are CNT_W wide and never wrap, because err_num <= T_LEN.

Decomposition:
- gf_pkg holds SYMB_WIDTH, T_LEN, and new constants CNT_W and TAG_W.
- gf_pkg also holds typedef symb_t and an enum forney_state_t {IDLE, ISSUE, DRAIN, DONE}.
- The evaluator datapath is a separate sub-module, rs_forney_eval, sitting outside this block and connected via the ev_* ports. The scheduler itself is one module with no sub-modules.

Test Plan:
1. Evaluator model returns mag = pos ^ 8'h5A three cycles after issue, in order, ev_rdy=1. Send positions {8,17,95,111,162,169,174,196}, err_num=8 -> 8 consecutive issues with tags 0..7; out_vld at cycle 8+3+1 after transfer; err_values[0]=8'h52, err_values[7]=8'h9E; err_fail=0.
2. err_num=3, evaluator returns tags in order 2,0,1 with ev_rdy toggling 1/0 -> ev_pos stable while stalled; err_values[0..2] correct, [3..7]=0; out_vld held 4 cycles with out_rdy=0 and outputs unchanged.
3. err_num=0 -> out_vld the cycle after transfer, err_values all 0, err_fail=0, no ev_vld. err_num=9 -> out_vld, err_fail=1, no ev_vld.
4. err_num=4, tag 1 returns mag 0 -> err_fail=1 on out_vld. Next codeword err_num=2 with good mags -> err_fail=0.
5. areset asserted one cycle in DRAIN with 2 returns outstanding -> next cycle IDLE, err_rdy=1, out_vld=0. Stray late returns cause no change. A following codeword completes correctly.
6. Duplicate return of tag 0 during err_num=2 -> ignored write, err_fail=1.
